// File: rtl/dma_xfer_engine.sv
// DMA transfer engine: copies LEN_REG words from SRC_REG to DST_REG over one ICB master port.
// Optional build macro DMA_IRQ_EN enables the registered dma_irq output (tied 0 otherwise).
module dma_xfer_engine #(
    parameter int RSP_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] CTR,
    input  logic [31:0] CR,
    input  logic [31:0] SRC_REG,
    input  logic [31:0] DST_REG,
    input  logic [31:0] LEN_REG,
    output logic [31:0] SR,
    output logic        dma_irq,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_addr,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready,
    input  logic [31:0] m_icb_rsp_rdata,
    input  logic        m_icb_rsp_err
);

    localparam int TO_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_RSP,
        S_WR_CMD,
        S_WR_RSP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_remain;
    logic [TO_W-1:0]  r_to_cnt;

    logic             r_done;
    logic             r_err;
    logic             r_busy;
    logic             r_tmo;
    logic             r_abort;

    logic             w_len_zero;
    logic [CNT_W-1:0] w_remain_dec;
    logic             w_to_hit;
    logic             w_accept;
    logic             w_rsp_enter;
    logic             w_rd_take;
    logic             w_wr_ok;
    logic             w_exit_done;
    logic             w_exit_err;
    logic             w_exit_tmo;
    logic             w_exit_abort;
    logic             w_unused;

    assign w_len_zero   = (LEN_REG[CNT_W-1:0] == '0);
    assign w_remain_dec = r_remain - CNT_W'(1);
    assign w_to_hit     = (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));

    // Responses are always accepted so stray late responses drain harmlessly in IDLE.
    assign m_icb_rsp_ready = 1'b1;

    assign SR = {27'b0, r_abort, r_tmo, r_busy, r_err, r_done};

    // Control bits outside [0]/[1]/[7] and the low address bits are intentionally ignored.
    assign w_unused = ^{CTR, CR, SRC_REG[1:0], DST_REG[1:0], LEN_REG};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_rsp_enter     = 1'b0;
        w_rd_take       = 1'b0;
        w_wr_ok         = 1'b0;
        w_exit_done     = 1'b0;
        w_exit_err      = 1'b0;
        w_exit_tmo      = 1'b0;
        w_exit_abort    = 1'b0;
        m_icb_cmd_valid = 1'b0;
        m_icb_cmd_read  = 1'b0;
        m_icb_cmd_addr  = 32'h0;
        m_icb_cmd_wdata = 32'h0;
        m_icb_cmd_wmask = 4'h0;

        case (r_state)
            S_IDLE: begin
                if (CR[7] && CTR[0]) begin
                    w_accept = 1'b1;
                    if (w_len_zero) begin
                        w_exit_done = 1'b1;
                    end else begin
                        w_state_nxt = S_RD_CMD;
                    end
                end
            end

            S_RD_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_read  = 1'b1;
                m_icb_cmd_addr  = r_src;
                if (m_icb_cmd_ready) begin
                    w_rsp_enter = 1'b1;
                    w_state_nxt = S_RD_RSP;
                end
            end

            S_RD_RSP: begin
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        w_exit_err  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rd_take   = 1'b1;
                        w_state_nxt = S_WR_CMD;
                    end
                end else if (w_to_hit) begin
                    w_exit_tmo  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_WR_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_addr  = r_dst;
                m_icb_cmd_wdata = r_data;
                m_icb_cmd_wmask = 4'hF;
                if (m_icb_cmd_ready) begin
                    w_rsp_enter = 1'b1;
                    w_state_nxt = S_WR_RSP;
                end
            end

            S_WR_RSP: begin
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        w_exit_err  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wr_ok = 1'b1;
                        // Abort is only honoured here, once the current word is fully written.
                        if (w_remain_dec == '0) begin
                            w_exit_done = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (!CTR[0]) begin
                            w_exit_abort = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end else begin
                            w_state_nxt = S_RD_CMD;
                        end
                    end
                end else if (w_to_hit) begin
                    w_exit_tmo  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer datapath: addresses, remaining count, data holding register, response timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src    <= 32'h0;
            r_dst    <= 32'h0;
            r_data   <= 32'h0;
            r_remain <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_src    <= {SRC_REG[31:2], 2'b00};
                r_dst    <= {DST_REG[31:2], 2'b00};
                r_remain <= LEN_REG[CNT_W-1:0];
            end
            if (w_rd_take) begin
                r_data <= m_icb_rsp_rdata;
            end
            if (w_wr_ok) begin
                r_src    <= r_src + 32'd4;
                r_dst    <= r_dst + 32'd4;
                r_remain <= w_remain_dec;
            end
            if (w_rsp_enter) begin
                r_to_cnt <= '0;
            end else if (r_state == S_RD_RSP || r_state == S_WR_RSP) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // Status bits are sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_accept) begin
                r_done  <= w_len_zero;
                r_err   <= 1'b0;
                r_busy  <= !w_len_zero;
                r_tmo   <= 1'b0;
                r_abort <= 1'b0;
            end else if (w_exit_done) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end else if (w_exit_err) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end else if (w_exit_tmo) begin
                r_err  <= 1'b1;
                r_tmo  <= 1'b1;
                r_busy <= 1'b0;
            end else if (w_exit_abort) begin
                r_abort <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

`ifdef DMA_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= CTR[1] & (r_done | r_err);
        end
    end

    assign dma_irq = r_irq;
`else
    assign dma_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Self-checking bench for dma_xfer_engine: zero-wait ICB slave model with error/mute/stray
// response injection and directed transfers with hand-computed expectations.
module tb_dma_xfer_engine;

    localparam int          RSP_TIMEOUT = 8;
    localparam logic [31:0] DKEY        = 32'hA5A5_0000;
`ifdef DMA_IRQ_EN
    localparam logic        EXP_IRQ     = 1'b1;
`else
    localparam logic        EXP_IRQ     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] CTR = 32'h0;
    logic [31:0] CR = 32'h0;
    logic [31:0] SRC_REG = 32'h0;
    logic [31:0] DST_REG = 32'h0;
    logic [31:0] LEN_REG = 32'h0;
    logic [31:0] SR;
    logic        dma_irq;
    logic        m_icb_cmd_valid;
    logic        m_icb_cmd_ready = 1'b1;
    logic        m_icb_cmd_read;
    logic [31:0] m_icb_cmd_addr;
    logic [31:0] m_icb_cmd_wdata;
    logic [3:0]  m_icb_cmd_wmask;
    logic        m_icb_rsp_valid = 1'b0;
    logic        m_icb_rsp_ready;
    logic [31:0] m_icb_rsp_rdata = 32'h0;
    logic        m_icb_rsp_err = 1'b0;

    always #5 clk = ~clk;

    dma_xfer_engine #(
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .CNT_W       (32)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .CTR             (CTR),
        .CR              (CR),
        .SRC_REG         (SRC_REG),
        .DST_REG         (DST_REG),
        .LEN_REG         (LEN_REG),
        .SR              (SR),
        .dma_irq         (dma_irq),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .m_icb_rsp_err   (m_icb_rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model log and fault-injection knobs.
    logic [31:0] rd_q[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          rd_cnt     = 0;
    int          err_idx    = -1;
    int          mute_idx   = -1;
    int          valid_seen = 0;
    int          mask_bad   = 0;
    bit          stray_req  = 1'b0;

    // Zero-wait slave: a handshake seen before an edge gets its response in the following cycle.
    initial begin : slave_model
        logic        hs;
        logic        resp;
        logic        err;
        logic [31:0] data;
        forever begin
            @(negedge clk);
            hs   = m_icb_cmd_valid && m_icb_cmd_ready;
            resp = 1'b0;
            err  = 1'b0;
            data = 32'h0;
            if (m_icb_cmd_valid) valid_seen++;
            if (hs) begin
                if (m_icb_cmd_read) begin
                    rd_q.push_back(m_icb_cmd_addr);
                    if (m_icb_cmd_wmask != 4'h0) mask_bad++;
                    resp = (rd_cnt != mute_idx);
                    err  = (rd_cnt == err_idx);
                    data = m_icb_cmd_addr ^ DKEY;
                    rd_cnt++;
                end else begin
                    wr_a_q.push_back(m_icb_cmd_addr);
                    wr_d_q.push_back(m_icb_cmd_wdata);
                    if (m_icb_cmd_wmask != 4'hF) mask_bad++;
                    resp = 1'b1;
                end
            end
            if (stray_req) begin
                stray_req = 1'b0;
                resp      = 1'b1;
                data      = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            #1;
            m_icb_rsp_valid = resp;
            m_icb_rsp_err   = err & resp;
            m_icb_rsp_rdata = data;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clr_log();
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        rd_cnt     = 0;
        err_idx    = -1;
        mute_idx   = -1;
        valid_seen = 0;
    endtask

    task automatic cfg(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        SRC_REG = s;
        DST_REG = d;
        LEN_REG = l;
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic pulse_start();
        @(negedge clk);
        CR = 32'h0000_0080;
        @(negedge clk);
        CR = 32'h0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (SR[2] && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_idle_busy", {31'b0, SR[2]}, 32'h0);
    endtask

    initial begin : stimulus
        int cyc;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_sr",        SR, 32'h0);
        check("rst_irq",       {31'b0, dma_irq}, 32'h0);
        check("rst_valid",     {31'b0, m_icb_cmd_valid}, 32'h0);
        check("rst_read",      {31'b0, m_icb_cmd_read}, 32'h0);
        check("rst_addr",      m_icb_cmd_addr, 32'h0);
        check("rst_wdata",     m_icb_cmd_wdata, 32'h0);
        check("rst_wmask",     {28'b0, m_icb_cmd_wmask}, 32'h0);
        check("rst_rsp_ready", {31'b0, m_icb_rsp_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four-word copy with zero-wait memory.
        CTR = 32'h1;
        cfg(32'h1000, 32'h2000, 32'd4);
        clr_log();
        pulse_start();
        check("t1_sr_busy", SR, 32'h4);
        wait_idle(cyc);
        check("t1_busy_cycles", 32'(cyc), 32'd16);
        check("t1_sr_done", SR, 32'h1);
        check("t1_n_reads", 32'(rd_q.size()), 32'd4);
        check("t1_n_writes", 32'(wr_a_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rd_addr%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hFFFF_FFFF,
                  32'h1000 + 32'(4 * i));
            check($sformatf("t1_wr_addr%0d", i), (i < wr_a_q.size()) ? wr_a_q[i] : 32'hFFFF_FFFF,
                  32'h2000 + 32'(4 * i));
            check($sformatf("t1_wr_data%0d", i), (i < wr_d_q.size()) ? wr_d_q[i] : 32'hFFFF_FFFF,
                  (32'h1000 + 32'(4 * i)) ^ DKEY);
        end

        // Zero length: done immediately, no bus traffic.
        cfg(32'h1000, 32'h2000, 32'd0);
        clr_log();
        pulse_start();
        check("t2_sr_done", SR, 32'h1);
        repeat (4) @(negedge clk);
        check("t2_no_valid", 32'(valid_seen), 32'd0);
        check("t2_sr_hold", SR, 32'h1);

        // Error on the second read; then a restart clears status.
        cfg(32'h3000, 32'h4000, 32'd3);
        clr_log();
        err_idx = 1;
        pulse_start();
        wait_idle(cyc);
        check("t3_sr_err", SR, 32'h2);
        check("t3_n_reads", 32'(rd_q.size()), 32'd2);
        check("t3_n_writes", 32'(wr_a_q.size()), 32'd1);
        clr_log();
        pulse_start();
        check("t3_restart_busy", SR, 32'h4);
        wait_idle(cyc);
        check("t3_restart_done", SR, 32'h1);
        check("t3_restart_writes", 32'(wr_a_q.size()), 32'd3);

        // Response timeout on the first read, then a stray response while idle.
        cfg(32'h5000, 32'h6000, 32'd2);
        clr_log();
        mute_idx = 0;
        pulse_start();
        repeat (8) @(negedge clk);
        check("t4_sr_still_busy", SR, 32'h4);
        @(negedge clk);
        check("t4_sr_timeout", SR, 32'hA);
        check("t4_n_reads", 32'(rd_q.size()), 32'd1);
        check("t4_n_writes", 32'(wr_a_q.size()), 32'd0);
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_sr_after_stray", SR, 32'hA);
        check("t4_valid_seen", 32'(valid_seen), 32'd1);

        // Abort by clearing enable during the second word.
        cfg(32'h5000, 32'h6000, 32'd5);
        clr_log();
        pulse_start();
        repeat (5) @(negedge clk);
        CTR = 32'h0;
        wait_idle(cyc);
        check("t5_sr_abort", SR, 32'h10);
        check("t5_n_reads", 32'(rd_q.size()), 32'd2);
        check("t5_n_writes", 32'(wr_a_q.size()), 32'd2);
        check("t5_wr_addr1", (wr_a_q.size() > 1) ? wr_a_q[1] : 32'hFFFF_FFFF, 32'h6004);
        CTR = 32'h1;

        // Interrupt: enabled with CTR[1], suppressed without it.
        CTR = 32'h3;
        cfg(32'h1000, 32'h2000, 32'd1);
        clr_log();
        pulse_start();
        repeat (4) @(negedge clk);
        check("t6_sr_done", SR, 32'h1);
        check("t6_irq_not_yet", {31'b0, dma_irq}, 32'h0);
        @(negedge clk);
        check("t6_irq_rise", {31'b0, dma_irq}, {31'b0, EXP_IRQ});
        CTR = 32'h1;
        clr_log();
        pulse_start();
        wait_idle(cyc);
        repeat (2) @(negedge clk);
        check("t6_irq_masked", {31'b0, dma_irq}, 32'h0);
        check("t6_sr_done2", SR, 32'h1);

        // Start pulsed while busy is ignored.
        cfg(32'h7000, 32'h8000, 32'd4);
        clr_log();
        pulse_start();
        repeat (3) @(negedge clk);
        cfg(32'h9000, 32'hA000, 32'd1);
        pulse_start();
        wait_idle(cyc);
        check("t7_rest_cycles", 32'(cyc), 32'd11);
        check("t7_sr_done", SR, 32'h1);
        check("t7_n_reads", 32'(rd_q.size()), 32'd4);
        check("t7_n_writes", 32'(wr_a_q.size()), 32'd4);
        check("t7_last_wr", (wr_a_q.size() > 3) ? wr_a_q[3] : 32'hFFFF_FFFF, 32'h800C);

        // Asynchronous reset while a read command is being presented.
        cfg(32'h1000, 32'h2000, 32'd4);
        pulse_start();
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_sr", SR, 32'h0);
        check("t8_rst_valid", {31'b0, m_icb_cmd_valid}, 32'h0);
        check("t8_rst_addr", m_icb_cmd_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t8_idle_sr", SR, 32'h0);
        check("t8_idle_valid", {31'b0, m_icb_cmd_valid}, 32'h0);

        check("wmask_errors", 32'(mask_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
